fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, SHALL set address width; depth = 2**ADDR_WIDTH entries.
REQ-002 Parameter AF_LEVEL, default 6, SHALL set the almost-full occupancy threshold (1 .. depth-1).
REQ-003 Parameter AE_LEVEL, default 2, SHALL set the almost-empty occupancy threshold (1 .. depth-1).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 wr  input  1  SHALL be the write request: one push per cycle while high.
REQ-007 rd  input  1  SHALL be the read request: one pop per cycle while high.
REQ-008 clr_err  input  1  SHALL be a synchronous clear of the sticky overflow/underflow flags.
REQ-009 w_en  output  1  SHALL be the write enable to the storage array (combinational).
REQ-010 w_addr  output  ADDR_WIDTH  SHALL be the write pointer to the storage array (registered).
REQ-011 r_addr  output  ADDR_WIDTH  SHALL be the read pointer to the storage array (registered); storage read is asynchronous, so data at r_addr is the FIFO head.
REQ-012 full, empty  output  1 each  SHALL be the occupancy flags (registered).
REQ-013 almost_full, almost_empty  output  1 each  SHALL be the threshold flags (registered).
REQ-014 count  output  ADDR_WIDTH+1  SHALL be the current occupancy, 0 .. depth (registered).
REQ-015 overflow, underflow  output  1 each  SHALL be the sticky error flags (registered).

Function
REQ-016 push_ok = wr & (~full | rd); pop_ok = rd & ~empty; w_en SHALL equal push_ok.
REQ-017 On push_ok, w_addr SHALL increment by 1 modulo depth (wrap depth-1 -> 0).
REQ-018 On pop_ok, r_addr SHALL increment by 1 modulo depth (wrap depth-1 -> 0).
REQ-019 count SHALL: +1 on push_ok & ~pop_ok; -1 on pop_ok & ~push_ok; hold otherwise.
REQ-020 Flags SHALL reflect next-state count in the same edge: empty = (count==0), full = (count==depth), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-021 Full & wr & rd: both SHALL be accepted; count, full unchanged; both pointers advance; head data is read before the edge overwrites it.
REQ-022 Empty & wr & rd: write SHALL be accepted, read rejected (no fall-through); count 0 -> 1; underflow set.
REQ-023 wr & full & ~rd: write SHALL be dropped (w_en=0), pointers/count unchanged, overflow set.
REQ-024 rd & empty: read SHALL be dropped, r_addr unchanged, underflow set.
REQ-025 overflow/underflow SHALL stay set until clr_err; clr_err in the same cycle as a new error SHALL leave the flag set (set wins).
REQ-026 Pointer latency: a word written in cycle N SHALL be visible at the head no earlier than cycle N+1.

Reset
REQ-027 While rst_n=0, asynchronously: w_addr=0, r_addr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-028 w_en SHALL be 0 during reset regardless of wr.
REQ-029 Reset asserted mid-operation SHALL discard occupancy immediately; first edge after release SHALL behave as from empty.

Verification (ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2)
REQ-030 Reset release, idle -> empty=1, almost_empty=1, count=0, w_addr=r_addr=0, w_en=0.
REQ-031 8 writes, rd=0 -> count steps 1..8; almost_empty drops after 3rd; almost_full rises after 6th; full=1 after 8th; w_addr=0 (wrapped).
REQ-032 Full, 9th write alone -> w_en=0, count=8, overflow=1; then clr_err pulse -> overflow=0.
REQ-033 Full, wr=rd=1 for 4 cycles -> count=8 throughout, both pointers advance by 4, full stays 1, no overflow.
REQ-034 Empty, wr=rd=1 one cycle -> count=1, r_addr=0, w_addr=1, underflow=1; read-only on empty -> underflow stays 1, r_addr unchanged.
REQ-035 count=5, assert rst_n=0 between edges -> all outputs at reset values before next clk edge; after release, first write gives count=1, w_addr=1.

Source files
------------

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer, occupancy and status-flag controller
// Drives an external array with async read; pointers, count and flags are registered.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic                push_ok;
  logic                pop_ok;
  logic                ovf_evt;
  logic                udf_evt;
  logic [ADDR_WIDTH:0] count_nxt;

  // A simultaneous read frees the slot being written, so full does not block wr&rd.
  assign push_ok = wr & (~full | rd);
  assign pop_ok  = rd & ~empty;
  assign ovf_evt = wr & full & ~rd;
  assign udf_evt = rd & empty;
  assign w_en    = push_ok & rst_n;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + ONE_C;
    else if (pop_ok && !push_ok)
      count_nxt = count - ONE_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr       <= '0;
      r_addr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) w_addr <= w_addr + PTR_ONE;
      if (pop_ok)  r_addr <= r_addr + PTR_ONE;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      // A new error in the clearing cycle keeps its flag set.
      overflow     <= (overflow  & ~clr_err) | ovf_evt;
      underflow    <= (underflow & ~clr_err) | udf_evt;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, rd, clr_err;
  logic       w_en;
  logic [2:0] w_addr, r_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks   = 0;
  int failures = 0;

  fifo_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic c);
    wr = w; rd = r; clr_err = c;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_ae"},    32'(almost_empty), 1);
    check({tag, "_full"},  32'(full), 0);
    check({tag, "_af"},    32'(almost_full), 0);
    check({tag, "_waddr"}, 32'(w_addr), 0);
    check({tag, "_raddr"}, 32'(r_addr), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_udf"},   32'(underflow), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b1; rd = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    check("rst_wen_gated", 32'(w_en), 0);
    @(posedge clk); #1;
    check_reset_state("rst");
    wr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("idle");
    check("idle_wen", 32'(w_en), 0);

    // Fill: 8 writes
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check($sformatf("fill%0d_count", i), 32'(count), 32'(i));
      check($sformatf("fill%0d_ae", i),    32'(almost_empty), (i <= 2) ? 1 : 0);
      check($sformatf("fill%0d_af", i),    32'(almost_full),  (i >= 6) ? 1 : 0);
      check($sformatf("fill%0d_full", i),  32'(full),         (i == 8) ? 1 : 0);
      check($sformatf("fill%0d_waddr", i), 32'(w_addr),       32'(i % 8));
    end
    check("fill_empty", 32'(empty), 0);

    // Overflow write on full
    wr = 1'b1; #1;
    check("ovf_wen", 32'(w_en), 0);
    @(posedge clk); #1;
    wr = 1'b0;
    check("ovf_count", 32'(count), 8);
    check("ovf_waddr", 32'(w_addr), 0);
    check("ovf_flag",  32'(overflow), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 0);

    // Full with simultaneous read and write
    for (int i = 1; i <= 4; i++) begin
      wr = 1'b1; rd = 1'b1; #1;
      check($sformatf("frw%0d_wen", i), 32'(w_en), 1);
      cycle(1'b1, 1'b1, 1'b0);
      check($sformatf("frw%0d_count", i), 32'(count), 8);
      check($sformatf("frw%0d_full", i),  32'(full), 1);
    end
    check("frw_waddr", 32'(w_addr), 4);
    check("frw_raddr", 32'(r_addr), 4);
    check("frw_ovf",   32'(overflow), 0);

    // Drain
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 1'b0);
    check("drain_count", 32'(count), 0);
    check("drain_empty", 32'(empty), 1);
    check("drain_raddr", 32'(r_addr), 4);
    check("drain_udf",   32'(underflow), 0);

    // Empty with simultaneous read and write
    pulse_reset();
    check_reset_state("rst2");
    cycle(1'b1, 1'b1, 1'b0);
    check("erw_count", 32'(count), 1);
    check("erw_raddr", 32'(r_addr), 0);
    check("erw_waddr", 32'(w_addr), 1);
    check("erw_udf",   32'(underflow), 1);
    check("erw_empty", 32'(empty), 0);
    cycle(1'b0, 1'b1, 1'b0);
    check("pop_raddr", 32'(r_addr), 1);
    check("pop_empty", 32'(empty), 1);
    cycle(1'b0, 1'b1, 1'b0);
    check("udf_raddr", 32'(r_addr), 1);
    check("udf_flag",  32'(underflow), 1);
    check("udf_count", 32'(count), 0);
    cycle(1'b0, 1'b1, 1'b1);
    check("udf_setwins", 32'(underflow), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("udf_clr", 32'(underflow), 0);

    // Mid-operation asynchronous reset
    pulse_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 1'b0);
    check("mid_count5", 32'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    check("mid_count1", 32'(count), 1);
    check("mid_waddr1", 32'(w_addr), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
